// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and a saturating bubble-cycle counter.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_regwrite,
   input  logic              in_memread,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_regwrite,
   output logic              out_memread,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int BEAT_W = DATA_W + RD_W + 2;

   // With SKID=0 the FULL state is unreachable: combinational ready blocks
   // any accept that would need a second entry.
   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e            state_q, state_d;
   logic              ready_q;
   logic [BEAT_W-1:0] in_beat;
   logic [BEAT_W-1:0] main_q;
   logic [BEAT_W-1:0] skid_q;
   logic [CNT_W-1:0]  bubble_q;
   logic              accept;
   logic              emit;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;

   assign in_beat = {in_data, in_rd, in_regwrite, in_memread};

   // State register plus registered ready, which mirrors "state is not FULL".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != StFull);
      end
   end

   // Next-state and load-enable decode; flush overrides every transition.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d      = StOne;
                  load_main_in = 1'b1;
               end
            end
            StOne: begin
               if (accept && emit) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d   = StFull;
                  load_skid = 1'b1;
               end else if (emit) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (emit) begin
                  state_d        = StOne;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // Handshake and head-beat outputs; control bits gated so bubbles never write.
   always_comb begin
      out_valid    = (state_q != StEmpty);
      in_ready     = (SKID != 0) ? ready_q : (out_ready | ~out_valid);
      accept       = in_valid & in_ready;
      emit         = out_valid & out_ready;
      out_data     = main_q[BEAT_W-1 -: DATA_W];
      out_rd       = main_q[2 +: RD_W];
      out_regwrite = main_q[1] & out_valid;
      out_memread  = main_q[0] & out_valid;
      bubble_cnt   = bubble_q;
   end

   // Payload registers; contents may go stale after flush, valids do not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_beat;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_beat;
         end
      end
   end

   // Saturating count of edges at which the output held no beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_q <= '0;
      end else if (!out_valid && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_q <= bubble_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, non-skid and 3-bit-counter variants.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        in_memread;
   logic        out_ready;
   logic        sat_valid;

   logic        s_in_ready, s_out_valid, s_out_regwrite, s_out_memread;
   logic [31:0] s_out_data;
   logic [4:0]  s_out_rd;
   logic [15:0] s_bubble;

   logic        n_in_ready, n_out_valid, n_out_regwrite, n_out_memread;
   logic [31:0] n_out_data;
   logic [4:0]  n_out_rd;
   logic [15:0] n_bubble;

   logic        t_in_ready, t_out_valid, t_out_regwrite, t_out_memread;
   logic [31:0] t_out_data;
   logic [4:0]  t_out_rd;
   logic [2:0]  t_bubble;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .RD_W(5), .SKID(1), .CNT_W(16)) u_skid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_memread(in_memread),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_rd(s_out_rd), .out_regwrite(s_out_regwrite), .out_memread(s_out_memread),
      .bubble_cnt(s_bubble)
   );

   pipe_stage_reg #(.DATA_W(32), .RD_W(5), .SKID(0), .CNT_W(16)) u_noskid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_memread(in_memread),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
      .out_rd(n_out_rd), .out_regwrite(n_out_regwrite), .out_memread(n_out_memread),
      .bubble_cnt(n_bubble)
   );

   pipe_stage_reg #(.DATA_W(32), .RD_W(5), .SKID(1), .CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .flush(1'b0),
      .in_valid(sat_valid), .in_ready(t_in_ready), .in_data(in_data), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_memread(in_memread),
      .out_valid(t_out_valid), .out_ready(1'b1), .out_data(t_out_data),
      .out_rd(t_out_rd), .out_regwrite(t_out_regwrite), .out_memread(t_out_memread),
      .bubble_cnt(t_bubble)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic ordy);
      in_valid    = v;
      in_data     = d;
      in_rd       = rd;
      in_regwrite = rw;
      in_memread  = mr;
      out_ready   = ordy;
   endtask

   // Checks the skid instance's head beat and ready after an edge.
   task automatic chk_skid(input string tag, input logic v, input logic [31:0] d,
                           input logic rdy);
      chk({tag, "_valid"}, 32'(s_out_valid), 32'(v));
      if (v) chk({tag, "_data"}, s_out_data, d);
      chk({tag, "_ready"}, 32'(s_in_ready), 32'(rdy));
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      sat_valid = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      #2;
      chk("rst_s_valid", 32'(s_out_valid), 32'd0);
      chk("rst_s_ready", 32'(s_in_ready), 32'd1);
      chk("rst_s_bubble", 32'(s_bubble), 32'd0);
      chk("rst_n_ready", 32'(n_in_ready), 32'd1);
      chk("rst_n_data", n_out_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Idle: 3-bit counter saturates at 7, 16-bit counter keeps counting.
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 3) chk("sat_cnt3", 32'(t_bubble), 32'd3);
         if (i == 7) chk("sat_cnt7", 32'(t_bubble), 32'd7);
      end
      chk("sat_hold", 32'(t_bubble), 32'd7);
      chk("skid_bubble10", 32'(s_bubble), 32'd10);

      // Streaming, both modes: 8 back-to-back beats, one-cycle latency.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 5'(i), 1'b1, 1'(i % 2), 1'b1);
         #1;
         chk("strm_s_ready", 32'(s_in_ready), 32'd1);
         chk("strm_n_ready", 32'(n_in_ready), 32'd1);
         tick();
         chk("strm_s_valid", 32'(s_out_valid), 32'd1);
         chk("strm_s_data", s_out_data, 32'h100 + 32'(i));
         chk("strm_s_rd", 32'(s_out_rd), 32'(i));
         chk("strm_s_memrd", 32'(s_out_memread), 32'(i % 2));
         chk("strm_n_valid", 32'(n_out_valid), 32'd1);
         chk("strm_n_data", n_out_data, 32'h100 + 32'(i));
         chk("strm_n_rd", 32'(n_out_rd), 32'(i));
      end
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("strm_s_drain", 32'(s_out_valid), 32'd0);
      chk("strm_n_drain", 32'(n_out_valid), 32'd0);

      // Skid fill/drain: out_ready low while beats 2 and 3 are held.
      drive(1'b1, 32'h200, 5'd0, 1'b1, 1'b0, 1'b1); tick();
      chk_skid("sk_c0", 1'b1, 32'h200, 1'b1);
      drive(1'b1, 32'h201, 5'd1, 1'b1, 1'b0, 1'b1); tick();
      chk_skid("sk_c1", 1'b1, 32'h201, 1'b1);
      drive(1'b1, 32'h202, 5'd2, 1'b1, 1'b0, 1'b1); tick();
      chk_skid("sk_c2", 1'b1, 32'h202, 1'b1);
      drive(1'b1, 32'h203, 5'd3, 1'b1, 1'b0, 1'b0); tick();
      chk_skid("sk_c3", 1'b1, 32'h202, 1'b0);
      drive(1'b1, 32'h204, 5'd4, 1'b1, 1'b0, 1'b0); tick();
      chk_skid("sk_c4", 1'b1, 32'h202, 1'b0);
      tick();
      chk_skid("sk_c5", 1'b1, 32'h202, 1'b0);
      drive(1'b1, 32'h204, 5'd4, 1'b1, 1'b0, 1'b1); tick();
      chk_skid("sk_c6", 1'b1, 32'h203, 1'b1);
      tick();
      chk_skid("sk_c7", 1'b1, 32'h204, 1'b1);
      drive(1'b1, 32'h205, 5'd5, 1'b1, 1'b0, 1'b1); tick();
      chk_skid("sk_c8", 1'b1, 32'h205, 1'b1);
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
      chk_skid("sk_c9", 1'b0, 32'h0, 1'b1);

      // Flush from FULL with a beat offered.
      drive(1'b1, 32'h300, 5'd7, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h301, 5'd8, 1'b1, 1'b0, 1'b0); tick();
      chk_skid("fl_full", 1'b1, 32'h300, 1'b0);
      flush = 1'b1;
      drive(1'b1, 32'hDEAD, 5'd9, 1'b1, 1'b0, 1'b0); tick();
      flush = 1'b0;
      chk_skid("fl_after", 1'b0, 32'h0, 1'b1);
      chk("fl_regwrite", 32'(s_out_regwrite), 32'd0);
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
      chk_skid("fl_idle", 1'b0, 32'h0, 1'b1);

      // Flush from ONE: the beat accepted in the flush cycle is discarded.
      drive(1'b1, 32'h400, 5'd3, 1'b1, 1'b0, 1'b0); tick();
      chk_skid("fl1_one", 1'b1, 32'h400, 1'b1);
      flush = 1'b1;
      drive(1'b1, 32'hDEAD, 5'd4, 1'b1, 1'b0, 1'b0); tick();
      flush = 1'b0;
      chk_skid("fl1_after", 1'b0, 32'h0, 1'b1);
      chk("fl1_n_valid", 32'(n_out_valid), 32'd0);
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
      chk_skid("fl1_idle", 1'b0, 32'h0, 1'b1);

      // Control gating: held rd=31 beat must not present regwrite once gone.
      drive(1'b1, 32'h500, 5'd31, 1'b1, 1'b1, 1'b1); tick();
      chk("cg_s_rw_on", 32'(s_out_regwrite), 32'd1);
      chk("cg_s_mr_on", 32'(s_out_memread), 32'd1);
      chk("cg_s_rd", 32'(s_out_rd), 32'd31);
      chk("cg_n_rw_on", 32'(n_out_regwrite), 32'd1);
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
      chk("cg_s_valid", 32'(s_out_valid), 32'd0);
      chk("cg_s_rw_off", 32'(s_out_regwrite), 32'd0);
      chk("cg_s_mr_off", 32'(s_out_memread), 32'd0);
      chk("cg_n_rw_off", 32'(n_out_regwrite), 32'd0);
      chk("cg_n_mr_off", 32'(n_out_memread), 32'd0);

      // Asynchronous reset mid-stream with the skid instance FULL.
      drive(1'b1, 32'h600, 5'd1, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 32'h601, 5'd2, 1'b1, 1'b1, 1'b0); tick();
      chk("ar_full_ready", 32'(s_in_ready), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_valid", 32'(s_out_valid), 32'd0);
      chk("ar_data", s_out_data, 32'd0);
      chk("ar_rd", 32'(s_out_rd), 32'd0);
      chk("ar_regwrite", 32'(s_out_regwrite), 32'd0);
      chk("ar_memread", 32'(s_out_memread), 32'd0);
      chk("ar_ready", 32'(s_in_ready), 32'd1);
      chk("ar_bubble", 32'(s_bubble), 32'd0);
      chk("ar_n_valid", 32'(n_out_valid), 32'd0);
      chk("ar_t_bubble", 32'(t_bubble), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("ar_post_bubble", 32'(s_bubble), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing fixed per-stage latches such as the MEM/WB register. It carries a generic payload plus destination-register control fields, adds a valid/ready handshake with optional two-entry skid buffering, and supports synchronous flush. It also counts bubble cycles, so stall and hazard behaviour can be measured at any stage boundary.

## Interface
- DATA_W, 32, payload width (write-back data, ALU result, etc.)
- RD_W, 5, destination-register address width
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational ready
- CNT_W, 16, bubble-counter width
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous kill of all held beats
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  DATA_W  upstream payload
- in_rd  input  RD_W  destination register
- in_regwrite  input  1  beat writes the register file
- in_memread  input  1  beat read data memory
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  payload of head beat
- out_rd  output  RD_W  destination of head beat
- out_regwrite  output  1  head beat writes (forced 0 when !out_valid)
- out_memread  output  1  head beat is a load (forced 0 when !out_valid)
- bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0

## Operation
- Accept: in_valid & in_ready at a clk edge. Emit: out_valid & out_ready at a clk edge.
- A beat is {data, rd, regwrite, memread}; beats leave in order, unmodified.
- Reset: all valids 0; out_data, out_rd, out_regwrite, out_memread = 0; bubble_cnt = 0; in_ready = 1.
- SKID=0: one register. in_ready = out_ready | !out_valid (combinational). Accept loads the register; emit without accept clears out_valid.
- SKID=1: main and skid registers, with states EMPTY, ONE and FULL. in_ready is registered and equals 1 exactly when the state is not FULL.
  - EMPTY: accept goes to ONE, loading main.
  - ONE: accept plus emit stays in ONE, main loads the new beat. Accept without emit goes to FULL, loading skid. Emit without accept goes to EMPTY.
  - FULL: emit goes to ONE, with main taking skid. There is no accept in FULL.
- flush: at the next edge all valids clear and the state becomes EMPTY. A beat accepted in the flush cycle is discarded. An emit in the flush cycle still completes downstream. Payload registers may keep stale data. flush has priority over every other transition.
- Control gating: out_regwrite = main_regwrite & out_valid, and out_memread likewise. This ensures a bubble never appears as a register write to forwarding or hazard logic.
- bubble_cnt: increments by 1 at each edge where out_valid was 0. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Simultaneous reset and flush: reset wins.

## Timing
- Latency is 1 cycle, accept edge to out_valid high.
- Throughput is 1 beat/cycle while out_ready=1, in both modes.
- SKID=1 backpressure: if out_ready falls while in_valid=1, exactly one extra beat is accepted into skid. in_ready reads 0 from the following cycle.
- SKID=1 drain: the first edge with out_ready=1 in FULL emits main and moves skid to main. in_ready returns to 1 in the next cycle.
- SKID=1 gives no combinational path from out_ready to in_ready. SKID=0 has that path by design.
- Reset is asynchronous: outputs reach their reset values without waiting for clk. Deassertion is assumed to be synchronised upstream.

## Test plan
- Reset: assert reset mid-stream with the block in FULL. Required: all outputs immediately 0, in_ready=1, bubble_cnt=0.
- Streaming (both SKID values): 8 back-to-back beats, data=0x100+i, rd=i, out_ready=1. Required: each beat appears 1 cycle later in order, with no in_ready drop.
- Skid fill/drain (SKID=1): stream with out_ready low for 3 cycles starting at beat 2. Required: beats 2 and 3 are held, in_ready=0 for the remaining stall cycles, and the order is preserved with no loss or duplication on release.
- Flush with simultaneous accept: in FULL, assert flush with in_valid=1 and data=0xDEAD. Required: next cycle out_valid=0, out_regwrite=0, 0xDEAD is never emitted, and in_ready=1.
- Control gating: a beat with regwrite=1, rd=31 is emitted while in_valid=0. Required: the next cycle shows out_regwrite=0 and out_memread=0, regardless of the held rd.
- Counter saturation (CNT_W=3): 10 idle cycles after reset. Required: bubble_cnt reads 7 and holds; it does not wrap on further idle cycles.
